// File: rtl/fp32_div_seq.sv
// Iterative binary32 divider: radix-2 restoring quotient over 26 cycles, RNE rounding,
// flush-to-zero for subnormal inputs and outputs, valid/ready request and response ports.
module fp32_div_seq #(
    parameter logic [31:0] NAN_CODE = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] q
);
    localparam int unsigned ITER = 26;

    typedef enum logic [1:0] {StIdle, StDiv, StRound, StDone} state_e;

    state_e             state_q, state_d;
    logic        [25:0] rem_q, rem_d;
    logic        [25:0] quo_q, quo_d;
    logic        [23:0] mb_q, mb_d;
    logic        [4:0]  cnt_q, cnt_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic        [31:0] q_q, q_d;
    logic               out_valid_q, out_valid_d;

    // Operand classification on the live inputs; only used on the capture cycle.
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic res_nan, res_inf, res_zero, special, s_in;
    logic [31:0] spec_q;

    assign a_zero = (a[30:23] == 8'h00);
    assign b_zero = (b[30:23] == 8'h00);
    assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign s_in   = a[31] ^ b[31];

    assign res_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    assign res_inf  = a_inf | b_zero;
    assign res_zero = a_zero | b_inf;
    assign special  = res_nan | res_inf | res_zero;

    always_comb begin
        if (res_nan) begin
            spec_q = NAN_CODE;
        end else if (res_inf) begin
            spec_q = {s_in, 8'hFF, 23'd0};
        end else begin
            spec_q = {s_in, 31'd0};
        end
    end

    // Restoring step.
    logic        rem_ge;
    logic [25:0] diff;
    assign rem_ge = (rem_q >= {2'b00, mb_q});
    assign diff   = rem_q - {2'b00, mb_q};

    // Normalise, round to nearest even, range-limit.
    logic [23:0]       sig;
    logic              guard, sticky, round_up;
    logic [24:0]       sig_inc;
    logic signed [9:0] exp_n, exp_r;
    logic [31:0]       norm_q;
    logic              unused_sig_msb;

    always_comb begin
        if (quo_q[25]) begin
            sig    = quo_q[25:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (rem_q != 26'd0);
            exp_n  = exp_q;
        end else begin
            sig    = quo_q[24:1];
            guard  = quo_q[0];
            sticky = (rem_q != 26'd0);
            exp_n  = exp_q - 10'sd1;
        end
        round_up = guard & (sticky | sig[0]);
        sig_inc  = {1'b0, sig} + {24'd0, round_up};
        // A carry leaves sig_inc = 1.0 with a zero fraction field, so only the exponent moves.
        exp_r    = sig_inc[24] ? exp_n + 10'sd1 : exp_n;
        if (exp_r >= 10'sd255) begin
            norm_q = {sign_q, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            norm_q = {sign_q, 31'd0};
        end else begin
            norm_q = {sign_q, exp_r[7:0], sig_inc[22:0]};
        end
    end
    assign unused_sig_msb = sig_inc[23];

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        mb_d        = mb_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        q_d         = q_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d = s_in;
                    rem_d  = {2'b01, a[22:0]};
                    mb_d   = {1'b1, b[22:0]};
                    quo_d  = 26'd0;
                    cnt_d  = 5'd0;
                    exp_d  = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
                    if (special) begin
                        q_d     = spec_q;
                        state_d = StDone;
                    end else begin
                        state_d = StDiv;
                    end
                end
            end
            StDiv: begin
                quo_d = {quo_q[24:0], rem_ge};
                rem_d = rem_ge ? (diff << 1) : (rem_q << 1);
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER - 1)) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                q_d         = norm_q;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                // Special results arrive here with out_valid low and raise it one cycle later.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rem_q       <= 26'd0;
            quo_q       <= 26'd0;
            mb_q        <= 24'd0;
            cnt_q       <= 5'd0;
            exp_q       <= 10'sd0;
            sign_q      <= 1'b0;
            q_q         <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            mb_q        <= mb_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            q_q         <= q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign q         = q_q;
endmodule

// File: tb/tb_fp32_div_seq.sv
// Scoreboard bench for fp32_div_seq: stimulus pushes expected results, a monitor pops and
// compares each accepted response, including latency from the transfer edge.
module tb_fp32_div_seq;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;

    fp32_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q)
    );

    typedef struct {
        string       name;
        logic [31:0] q;
        int          lat;
        int          k;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   seen   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: first sighting of out_valid checks latency, acceptance checks the value.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got q=%h with no pending request", q);
            end else begin
                if (!seen) begin
                    check({sb[0].name, "_latency"}, 32'(cyc - sb[0].k), 32'(sb[0].lat));
                    seen = 1;
                end
                if (out_ready) begin
                    check({sb[0].name, "_q"}, q, sb[0].q);
                    check({sb[0].name, "_in_ready_at_accept"}, {31'd0, in_ready}, 32'd0);
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input string name, input logic [31:0] ta, input logic [31:0] tb_op,
                         input logic [31:0] exp, input int lat);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_issue_timeout: got in_ready=0 expected 1", name);
        end else begin
            a        = ta;
            b        = tb_op;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            e.name   = name;
            e.q      = exp;
            e.lat    = lat;
            e.k      = cyc;
            sb.push_back(e);
            // Scramble operands after capture; the result in flight must not change.
            a = 32'h12345678;
            b = 32'h3F000001;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
            seen = 0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        b         = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_q", q, 32'd0);

        // Normal datapath
        issue("div_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 27);
        drain();
        issue("div_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 27);
        drain();
        issue("div_1_1", 32'h3F800000, 32'h3F800000, 32'h3F800000, 27);
        drain();
        issue("div_neg", 32'hC0C00000, 32'h40000000, 32'hC0400000, 27);
        drain();

        // Specials
        issue("one_by_negzero", 32'h3F800000, 32'h80000000, 32'hFF800000, 1);
        drain();
        issue("zero_by_zero", 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1);
        drain();
        issue("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'hFFFFFFFF, 1);
        drain();
        issue("two_by_inf", 32'h40000000, 32'h7F800000, 32'h00000000, 1);
        drain();
        issue("nan_by_one", 32'h7FC00000, 32'h3F800000, 32'hFFFFFFFF, 1);
        drain();

        // Range limits
        issue("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 27);
        drain();
        issue("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 27);
        drain();

        // Backpressure with an ignored mid-division request
        out_ready = 1'b0;
        issue("backpressure", 32'h40C00000, 32'h40000000, 32'h40400000, 27);
        repeat (5) @(negedge clk);
        a        = 32'h3F800000;
        b        = 32'h40400000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_q_stable", q, 32'h40400000);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        drain();
        check("no_ghost_request", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of division
        issue("aborted", 32'h40C00000, 32'h40000000, 32'h40400000, 27);
        repeat (11) @(posedge clk);
        @(negedge clk);
        sb.delete();
        seen = 0;
        rst  = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_q", q, 32'd0);
        issue("after_reset_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 27);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
